// File: rtl/inst_rom_responder.sv
// Instruction-fetch responder: translates a kseg1 PC to a ROM word index, inserts
// wait states, reads a 1-cycle synchronous ROM and returns {inst, pc, err}.
module inst_rom_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'hbfc00000,
    parameter logic [31:0] ERR_INST    = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_inst,
    output logic [31:0]           rsp_addr,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    output logic                  mem_en,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_READ, ST_CAPT, ST_RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           inst_q, inst_d;
    logic [31:0]           raddr_q, raddr_d;
    logic                  err_q, err_d;

    // Word-granular offset: with an aligned base, a borrow here is exactly the
    // borrow of the full byte subtraction, and misalignment is flagged separately.
    logic [30:0] word_off;
    logic        addr_err;
    logic        accept;

    assign word_off  = {1'b0, req_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign addr_err  = (req_addr[1:0] != 2'b00) || word_off[30]
                     || (word_off[29:DEPTH_LOG2] != '0);
    assign req_ready = (state_q == ST_IDLE) && !flush && resetn;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        raddr_d = raddr_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pc_d = req_addr;
                    if (addr_err) begin
                        err_d   = 1'b1;
                        inst_d  = ERR_INST;
                        raddr_d = req_addr;
                        state_d = ST_RESP;
                    end else begin
                        idx_d = word_off[DEPTH_LOG2-1:0];
                        if (WAIT_CYCLES == 0) begin
                            state_d = ST_READ;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = WAIT_INIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_READ;
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: begin
                inst_d  = mem_rdata;
                raddr_d = pc_q;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A redirect abandons whatever fetch is in progress, including a pending response.
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
            raddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            raddr_q <= raddr_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_inst  = inst_q;
    assign rsp_addr  = raddr_q;
    assign rsp_err   = err_q;
    assign mem_en    = (state_q == ST_READ);
    assign mem_addr  = idx_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Randomized bench for inst_rom_responder against a transaction-level model of
// the address window, response latency and ROM contents.
module tb_inst_rom_responder;

    localparam logic [31:0] BASE  = 32'hbfc00000;
    localparam int          WAITC = 2;
    localparam int          WORDS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, req_valid, flush, rsp_ready;
    logic [31:0] req_addr;
    logic        req_ready, rsp_valid, rsp_err, mem_en;
    logic [31:0] rsp_inst, rsp_addr, mem_rdata;
    logic [9:0]  mem_addr;

    logic        b_req_valid, b_flush, b_rsp_ready;
    logic [31:0] b_req_addr;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_en;
    logic [31:0] b_rsp_inst, b_rsp_addr, b_mem_rdata;
    logic [9:0]  b_mem_addr;

    inst_rom_responder dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .rsp_valid(rsp_valid),
        .rsp_inst(rsp_inst), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata)
    );

    inst_rom_responder #(.WAIT_CYCLES(0)) dut_nowait (
        .clk(clk), .resetn(resetn), .req_valid(b_req_valid), .req_addr(b_req_addr),
        .req_ready(b_req_ready), .flush(b_flush), .rsp_valid(b_rsp_valid),
        .rsp_inst(b_rsp_inst), .rsp_addr(b_rsp_addr), .rsp_err(b_rsp_err),
        .rsp_ready(b_rsp_ready), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
        .mem_rdata(b_mem_rdata)
    );

    logic [31:0] rom [WORDS];
    int          men_cnt = 0;
    logic [9:0]  last_maddr = '0;

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata  <= rom[mem_addr];
            men_cnt    <= men_cnt + 1;
            last_maddr <= mem_addr;
        end
        if (b_mem_en) b_mem_rdata <= rom[b_mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the ROM window is [BASE, BASE + 4*WORDS), word aligned.
    function automatic bit m_err(input logic [31:0] a);
        longint off;
        off = {32'd0, a} - {32'd0, BASE};
        return (a % 4 != 0) || (off < 0) || (off >= 4 * WORDS);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    logic [31:0] e_inst, e_addr;
    logic        e_err;

    task automatic issue(input logic [31:0] a);
        int lat;
        int m0;
        bit er;
        er = m_err(a);
        chk("req_ready_idle", 32'(req_ready), 1);
        m0 = men_cnt;
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e_err  = er;
        e_addr = a;
        e_inst = er ? 32'h0 : rom[m_idx(a)];
        chk("latency", lat, er ? 1 : WAITC + 3);
        chk("rsp_inst", rsp_inst, e_inst);
        chk("rsp_addr", rsp_addr, e_addr);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("mem_en_pulses", men_cnt - m0, er ? 0 : 1);
        if (!er) chk("mem_addr", 32'(last_maddr), m_idx(a));
    endtask

    task automatic drain(input int hold);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_inst", rsp_inst, e_inst);
            chk("hold_addr", rsp_addr, e_addr);
            chk("hold_err", 32'(rsp_err), 32'(e_err));
            chk("hold_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        #1;
        chk("consumed_valid", 32'(rsp_valid), 0);
        chk("consumed_req_ready", 32'(req_ready), 1);
    endtask

    // Accept a good fetch and flush it during cycle k after acceptance.
    task automatic flush_at(input logic [31:0] a, input int k);
        int m0;
        int seen;
        m0 = men_cnt;
        seen = 0;
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int j = 1; j < k; j++) begin
            @(posedge clk); #1;
        end
        flush     = 1'b1;
        rsp_ready = 1'($urandom);
        @(posedge clk); #1;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("flush_valid", 32'(rsp_valid), 0);
        chk("flush_req_ready", 32'(req_ready), 1);
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("flush_no_rsp", seen, 0);
        chk("flush_mem_en", men_cnt - m0, (k >= WAITC + 1) ? 1 : 0);
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 4))
            0:       return BASE + 4 * $urandom_range(0, WORDS - 1);
            1:       return BASE + $urandom_range(0, 4 * WORDS - 1);
            2:       return $urandom;
            3:       return BASE - 4 * $urandom_range(1, 4);
            default: return BASE + 4 * WORDS + 4 * $urandom_range(0, 8);
        endcase
    endfunction

    initial begin
        int lat;
        int m0;
        int seen;
        for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
        rom[0] = 32'h3c010001;
        resetn = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_flush = 1'b0; b_rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_inst", rsp_inst, 0);
        chk("rst_addr", rsp_addr, 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        resetn = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 1);

        issue(BASE);                drain(0);
        issue(BASE + 32'd20);       drain(3);
        issue(32'hbfc00006);        drain(0);
        issue(32'hbfc01000);        drain(0);
        issue(32'h00000000);        drain(0);
        issue(32'hffffffff);        drain(1);
        issue(32'hbfc00ffc);        drain(0);

        flush_at(BASE + 32'd8, 2);
        issue(32'hbfc00004);        drain(0);

        // Flush and request together in IDLE: nothing may be accepted.
        m0 = men_cnt;
        seen = 0;
        req_valid = 1'b1; req_addr = BASE; flush = 1'b1;
        #1;
        chk("flush_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("flush_req_no_rsp", seen, 0);
        chk("flush_req_no_mem", men_cnt - m0, 0);

        // Reset while a response is pending.
        issue(BASE + 32'd12);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_inst", rsp_inst, 0);
        chk("mid_rst_addr", rsp_addr, 0);
        chk("mid_rst_err", 32'(rsp_err), 0);
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 1);

        // Zero-wait-state instance.
        chk("nowait_req_ready", 32'(b_req_ready), 1);
        b_req_valid = 1'b1; b_req_addr = BASE + 32'd8;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        lat = 1;
        while (!b_rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("nowait_latency", lat, 3);
        chk("nowait_inst", b_rsp_inst, rom[2]);
        chk("nowait_addr", b_rsp_addr, BASE + 32'd8);
        chk("nowait_err", 32'(b_rsp_err), 0);

        repeat (60) begin
            if ($urandom_range(0, 4) == 0) begin
                flush_at(BASE + 4 * $urandom_range(0, WORDS - 1), $urandom_range(1, WAITC + 3));
            end else begin
                issue(rnd_addr());
                drain($urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
